// File: rtl/serial_sub4_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states, default width
// and the bit-counter sizing helper.
package serial_sub4_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_sub_bit.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module full_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial subtractor: DIFF = A - B - BIN processed LSB first, one bit per
// cycle, with a one-cycle done pulse once the full result is in place.
module serial_sub4
  import serial_sub4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOUT,
  output logic             busy,
  output logic             done
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             bout_q;
  logic [CW-1:0]    cnt_q;

  logic             d_bit;
  logic             borrow_d;
  logic [WIDTH-1:0] diff_d;

  full_sub_bit u_bit (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .d    (d_bit),
    .bout (borrow_d)
  );

  // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  assign diff_d = {d_bit, diff_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= BIN;
            cnt_q    <= '0;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          borrow_q <= borrow_d;
          diff_q   <= diff_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            bout_q  <= borrow_d;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign DIFF = diff_q;
  assign BOUT = bout_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_sub4.sv
// Self-checking bench for serial_sub4: transaction-level model of A - B - BIN
// compared every cycle, plus directed cases with hand-computed results.
module tb_serial_sub4;

  localparam int W = 4;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A     = '0;
  logic [W-1:0] B     = '0;
  logic         BIN   = 1'b0;
  logic [W-1:0] DIFF;
  logic         BOUT;
  logic         busy;
  logic         done;

  serial_sub4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .BIN   (BIN),
    .DIFF  (DIFF),
    .BOUT  (BOUT),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int n_tests  = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;
  bit in_sweep = 1'b0;
  int last_done = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Model: phase 0 = idle, 1..W = computing, W+1 = result presented.
  int           m_phase = 0;
  logic [W:0]   m_res   = '0;
  logic [W-1:0] m_diff  = '0;
  logic         m_bout  = 1'b0;
  logic [W-1:0] m_a     = '0;
  logic [W-1:0] m_b     = '0;
  logic         m_bin   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_diff  <= '0;
      m_bout  <= 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase <= 1;
        m_res   <= {1'b0, A} - {1'b0, B} - {{W{1'b0}}, BIN};
        m_a     <= A;
        m_b     <= B;
        m_bin   <= BIN;
      end
    end else if (m_phase == W + 1) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
      if (m_phase == W) begin
        m_diff <= m_res[W-1:0];
        m_bout <= m_res[W];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, busy}, {31'd0, m_phase != 0});
      check("done", {31'd0, done}, {31'd0, m_phase == W + 1});
      if (m_phase == 0 || m_phase == W + 1) begin
        check("DIFF", {28'd0, DIFF}, {28'd0, m_diff});
        check("BOUT", {31'd0, BOUT}, {31'd0, m_bout});
      end
      if (m_phase == W + 1)
        $display("[TB] op A=%b B=%b BIN=%b -> DIFF=%b BOUT=%b", m_a, m_b, m_bin, DIFF, BOUT);
      if (done) begin
        done_cnt++;
        if (in_sweep && last_done >= 0)
          check("done_gap", cyc - last_done, W + 2);
        last_done = cyc;
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 back in idle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input bit scramble, output logic [W-1:0] d, output logic bo,
                       output int lat);
    int n;
    n = 0;
    A = a; B = b; BIN = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (scramble) begin
      A = W'($urandom); B = W'($urandom); BIN = 1'($urandom);
    end
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 3 * W);
    check("done_seen", {31'd0, done}, 32'd1);
    lat = n; d = DIFF; bo = BOUT;
    @(posedge clk); #1;
  endtask

  logic [W-1:0] r_d;
  logic         r_b;
  int           lat;
  int           base;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;
    check("rst_DIFF", {28'd0, DIFF}, 32'd0);
    check("rst_BOUT", {31'd0, BOUT}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_op(4'b0101, 4'b0011, 1'b0, 1'b0, r_d, r_b, lat);
    check("c1_lat", lat, 5);
    check("c1_DIFF", {28'd0, r_d}, 32'b0010);
    check("c1_BOUT", {31'd0, r_b}, 32'd0);

    do_op(4'b0011, 4'b0101, 1'b0, 1'b0, r_d, r_b, lat);
    check("c2a_DIFF", {28'd0, r_d}, 32'b1110);
    check("c2a_BOUT", {31'd0, r_b}, 32'd1);
    do_op(4'b0000, 4'b0000, 1'b1, 1'b0, r_d, r_b, lat);
    check("c2b_DIFF", {28'd0, r_d}, 32'b1111);
    check("c2b_BOUT", {31'd0, r_b}, 32'd1);

    do_op(4'b0111, 4'b0111, 1'b0, 1'b0, r_d, r_b, lat);
    check("eq_DIFF", {28'd0, r_d}, 32'd0);
    check("eq_BOUT", {31'd0, r_b}, 32'd0);
    do_op(4'b1111, 4'b0000, 1'b0, 1'b0, r_d, r_b, lat);
    check("max_DIFF", {28'd0, r_d}, 32'b1111);
    check("max_BOUT", {31'd0, r_b}, 32'd0);

    // Exhaustive sweep with start held high.
    in_sweep = 1'b1;
    last_done = -1;
    base = done_cnt;
    start = 1'b1;
    for (int i = 0; i < 512; i++) begin
      int g;
      A = i[8:5]; B = i[4:1]; BIN = i[0];
      g = 0;
      while (m_phase != 0 && g < 20) begin
        @(posedge clk); #1;
        g++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (W + 2) @(posedge clk);
    #1;
    in_sweep = 1'b0;
    check("sweep_dones", done_cnt - base, 512);

    // Start held during RUN and DONE must be ignored.
    A = 4'b0100; B = 4'b1001; BIN = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k <= W; k++) begin
      A = W'($urandom); B = W'($urandom); BIN = 1'($urandom); start = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("busy_ign_DIFF", {28'd0, DIFF}, 32'b1011);
    check("busy_ign_BOUT", {31'd0, BOUT}, 32'd1);
    check("busy_ign_idle", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("no_second_op", {31'd0, busy}, 32'd0);

    // Reset during RUN bit 2 aborts the operation.
    A = 4'b0110; B = 4'b0001; BIN = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    base = done_cnt;
    rst = 1'b1;
    #1;
    check("abort_DIFF", {28'd0, DIFF}, 32'd0);
    check("abort_BOUT", {31'd0, BOUT}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (W + 3) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - base, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(4'b1111, 4'b1111, 1'b0, 1'b0, r_d, r_b, lat);
    check("post_rst_lat", lat, 5);
    check("post_rst_DIFF", {28'd0, r_d}, 32'd0);
    check("post_rst_BOUT", {31'd0, r_b}, 32'd0);

    // Operands change right after acceptance.
    do_op(4'b1100, 4'b0101, 1'b1, 1'b1, r_d, r_b, lat);
    check("scr_DIFF", {28'd0, r_d}, 32'b0110);
    check("scr_BOUT", {31'd0, r_b}, 32'd0);
    for (int k = 0; k < 30; k++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, r_d, r_b, lat);

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
